alu_arbiter: RTL and testbench

- Shares the single 32-bit combinational ALU between two requesters, e.g. the pipeline EX stage (port 0) and the multicycle/auxiliary sequencer (port 1).
- Accepts one operation at a time over a valid/ready request channel and sequences it through the ALU.
- Returns the registered result to the owning requester over a valid/ready response channel.
- Arbitration is round-robin.

---
 rtl/alu_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation is accepted in IDLE, executed for one cycle, then held in RESP until consumed.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data1,
  input  logic [DATA_W-1:0] req0_data2,
  input  logic [OPC_W-1:0]  req0_opcode,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data1,
  input  logic [DATA_W-1:0] req1_data2,
  input  logic [OPC_W-1:0]  req1_opcode,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,

  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [OPC_W-1:0]  alu_opcode,
  input  logic [DATA_W-1:0] alu_result,

  output logic              busy,
  output logic              last_grant
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   data1_q;
  logic [DATA_W-1:0]   data2_q;
  logic [OPC_W-1:0]    opcode_q;
  logic                owner_q;
  logic [DATA_W-1:0]   result_q;
  logic                last_grant_q;

  logic                gnt0;
  logic                gnt1;
  logic                accept;
  logic                resp_hs;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && (state_q == StIdle)) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign accept  = gnt0 | gnt1;
  assign resp_hs = (state_q == StResp) && (owner_q ? resp1_ready : resp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      data1_q      <= '0;
      data2_q      <= '0;
      opcode_q     <= '0;
      owner_q      <= 1'b0;
      result_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            data1_q      <= gnt1 ? req1_data1  : req0_data1;
            data2_q      <= gnt1 ? req1_data2  : req0_data2;
            opcode_q     <= gnt1 ? req1_opcode : req0_opcode;
            owner_q      <= gnt1;
            last_grant_q <= gnt1;
            state_q      <= StExec;
          end
        end
        StExec: begin
          result_q <= alu_result;
          state_q  <= StResp;
        end
        StResp: begin
          if (resp_hs) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req0_ready   = gnt0;
  assign req1_ready   = gnt1;

  assign resp0_valid  = (state_q == StResp) && !owner_q;
  assign resp1_valid  = (state_q == StResp) && owner_q;
  assign resp0_result = owner_q ? '0 : result_q;
  assign resp1_result = owner_q ? result_q : '0;

  // Opcode 0 is the ALU NOP, so the ALU idles outside the execute cycle.
  assign alu_data1    = data1_q;
  assign alu_data2    = data2_q;
  assign alu_opcode   = (state_q == StExec) ? opcode_q : '0;

  assign busy         = (state_q != StIdle);
  assign last_grant   = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// transaction-level scoreboard, with a behavioural ALU attached to the ALU port.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic [31:0] req0_data1, req0_data2, resp0_result;
  logic [3:0]  req0_opcode;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [31:0] req1_data1, req1_data2, resp1_result;
  logic [3:0]  req1_opcode;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic [3:0]  alu_opcode;
  logic        busy, last_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .OPC_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_opcode(req0_opcode), .resp0_valid(resp0_valid),
    .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_opcode(req1_opcode), .resp1_valid(resp1_valid),
    .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .busy(busy), .last_grant(last_grant)
  );

  // Reference ALU: 1 add, 2 sub, 3 and, 4 or, 5 xor, everything else 0.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_data1, alu_data2);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req0_valid = 0; req0_data1 = 0; req0_data2 = 0; req0_opcode = 0; resp0_ready = 0;
    req1_valid = 0; req1_data1 = 0; req1_data2 = 0; req1_opcode = 0; resp1_ready = 0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    req0_valid = 1; req1_valid = 1;
    tick();
    tick();
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid got %b%b exp 00", resp0_valid, resp1_valid); end
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (last_grant !== 1'b1) begin
      errors++; $display("FAIL reset_last_grant got %b exp 1", last_grant); end
    checks++; if (alu_opcode !== 4'h0 || alu_data1 !== 32'h0 || alu_data2 !== 32'h0) begin
      errors++; $display("FAIL reset_alu got op %h d1 %h d2 %h exp 0", alu_opcode, alu_data1,
                         alu_data2); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_add;
    apply_reset();
    req0_valid = 1; req0_data1 = 32'h5; req0_data2 = 32'hA; req0_opcode = 4'b0001;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL add_ready got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    req0_valid = 0;
    #1;
    checks++; if (busy !== 1'b1 || alu_opcode !== 4'b0001 || alu_data1 !== 32'h5) begin
      errors++; $display("FAIL add_exec got busy %b op %h d1 %h exp 1 1 5", busy, alu_opcode,
                         alu_data1); end
    checks++; if (resp0_valid !== 1'b0) begin
      errors++; $display("FAIL add_early_valid got %b exp 0", resp0_valid); end
    tick();
    #1;
    checks++; if (resp0_valid !== 1'b1 || resp0_result !== 32'hF) begin
      errors++; $display("FAIL add_resp got v %b r %h exp 1 0000000f", resp0_valid,
                         resp0_result); end
    checks++; if (resp1_valid !== 1'b0 || resp1_result !== 32'h0) begin
      errors++; $display("FAIL add_nonowner got v %b r %h exp 0 0", resp1_valid,
                         resp1_result); end
    resp1_ready = 1;
    tick();
    #1;
    checks++; if (resp0_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL add_nonowner_ready got v %b busy %b exp 1 1", resp0_valid,
                         busy); end
    resp1_ready = 0; resp0_ready = 1;
    tick();
    resp0_ready = 0;
    #1;
    checks++; if (busy !== 1'b0 || resp0_valid !== 1'b0 || last_grant !== 1'b0) begin
      errors++; $display("FAIL add_done got busy %b v %b lg %b exp 0 0 0", busy, resp0_valid,
                         last_grant); end
  endtask

  task automatic test_tie_rr;
    apply_reset();
    req0_valid = 1; req0_data1 = 32'h5;  req0_data2 = 32'hA;  req0_opcode = 4'b0010;
    req1_valid = 1; req1_data1 = 32'hF0; req1_data2 = 32'h3C; req1_opcode = 4'b0011;
    resp0_ready = 1; resp1_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL tie_first got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    req0_valid = 0;
    #1;
    checks++; if (last_grant !== 1'b0) begin
      errors++; $display("FAIL tie_lg0 got %b exp 0", last_grant); end
    tick();
    #1;
    checks++; if (resp0_valid !== 1'b1 || resp0_result !== 32'hFFFFFFFB || resp1_valid !== 1'b0)
    begin
      errors++; $display("FAIL tie_resp0 got v %b r %h v1 %b exp 1 fffffffb 0", resp0_valid,
                         resp0_result, resp1_valid); end
    tick();
    #1;
    checks++; if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL tie_second got %b exp 1", req1_ready); end
    tick();
    req1_valid = 0;
    #1;
    checks++; if (last_grant !== 1'b1) begin
      errors++; $display("FAIL tie_lg1 got %b exp 1", last_grant); end
    tick();
    #1;
    checks++; if (resp1_valid !== 1'b1 || resp1_result !== 32'h30 || resp0_valid !== 1'b0) begin
      errors++; $display("FAIL tie_resp1 got v %b r %h v0 %b exp 1 00000030 0", resp1_valid,
                         resp1_result, resp0_valid); end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_pressure;
    apply_reset();
    req1_valid = 1; req1_data1 = 32'h7; req1_data2 = 32'h8; req1_opcode = 4'b0001;
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_data1 = 32'h1; req0_data2 = 32'h1; req0_opcode = 4'b0001;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (resp1_valid !== 1'b1 || resp1_result !== 32'hF) begin
        errors++; $display("FAIL bp_hold[%0d] got v %b r %h exp 1 0000000f", i, resp1_valid,
                           resp1_result); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d] got %b%b exp 00", i, req0_ready, req1_ready); end
      tick();
    end
    resp1_ready = 1;
    tick();
    resp1_ready = 0;
    #1;
    checks++; if (busy !== 1'b0 || req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_idle got busy %b rdy0 %b exp 0 1", busy, req0_ready); end
    req0_valid = 0;
    tick();
    #1;
    checks++; if (busy !== 1'b0 || last_grant !== 1'b1) begin
      errors++; $display("FAIL bp_withdraw got busy %b lg %b exp 0 1", busy, last_grant); end
  endtask

  task automatic test_fairness;
    logic exp_p;
    apply_reset();
    req0_valid = 1; req0_data1 = 32'hF0; req0_data2 = 32'h0F; req0_opcode = 4'b0100;
    req1_valid = 1; req1_data1 = 32'hFF; req1_data2 = 32'h0F; req1_opcode = 4'b0101;
    resp0_ready = 1; resp1_ready = 1;
    for (int i = 0; i < 6; i++) begin
      exp_p = 1'(i % 2);
      #1;
      checks++; if (req0_ready !== !exp_p || req1_ready !== exp_p) begin
        errors++; $display("FAIL fair_grant[%0d] got %b%b exp port %0d", i, req0_ready,
                           req1_ready, exp_p); end
      tick();
      #1;
      checks++; if (last_grant !== exp_p) begin
        errors++; $display("FAIL fair_lg[%0d] got %b exp %b", i, last_grant, exp_p); end
      tick();
      #1;
      if (exp_p) begin
        checks++; if (resp1_valid !== 1'b1 || resp1_result !== 32'hF0 || resp0_valid !== 1'b0)
        begin
          errors++; $display("FAIL fair_xor[%0d] got v %b r %h exp 1 000000f0", i, resp1_valid,
                             resp1_result); end
      end else begin
        checks++; if (resp0_valid !== 1'b1 || resp0_result !== 32'hFF || resp1_valid !== 1'b0)
        begin
          errors++; $display("FAIL fair_or[%0d] got v %b r %h exp 1 000000ff", i, resp0_valid,
                             resp0_result); end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_invalid_opcode;
    apply_reset();
    req0_valid = 1; req0_data1 = 32'h1234; req0_data2 = 32'h5; req0_opcode = 4'b1111;
    #1;
    checks++; if (alu_opcode !== 4'h0) begin
      errors++; $display("FAIL inv_idle_op got %h exp 0", alu_opcode); end
    tick();
    req0_valid = 0;
    #1;
    checks++; if (alu_opcode !== 4'hF || alu_data1 !== 32'h1234) begin
      errors++; $display("FAIL inv_exec got op %h d1 %h exp f 00001234", alu_opcode,
                         alu_data1); end
    tick();
    #1;
    checks++; if (resp0_valid !== 1'b1 || resp0_result !== 32'h0 || alu_opcode !== 4'h0) begin
      errors++; $display("FAIL inv_resp got v %b r %h op %h exp 1 0 0", resp0_valid,
                         resp0_result, alu_opcode); end
    resp0_ready = 1;
    tick();
    resp0_ready = 0;
    #1;
    checks++; if (busy !== 1'b0 || alu_opcode !== 4'h0) begin
      errors++; $display("FAIL inv_done got busy %b op %h exp 0 0", busy, alu_opcode); end
  endtask

  task automatic test_reset_in_resp;
    apply_reset();
    req0_valid = 1; req0_data1 = 32'h3; req0_data2 = 32'h4; req0_opcode = 4'b0001;
    tick();
    req0_valid = 0;
    tick();
    #1;
    checks++; if (resp0_valid !== 1'b1 || resp0_result !== 32'h7) begin
      errors++; $display("FAIL rr_pre got v %b r %h exp 1 00000007", resp0_valid,
                         resp0_result); end
    rst = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rr_ready_in_rst got %b%b exp 00", req0_ready, req1_ready); end
    tick();
    rst = 0;
    #1;
    checks++; if (resp0_valid !== 1'b0 || busy !== 1'b0 || last_grant !== 1'b1) begin
      errors++; $display("FAIL rr_post got v %b busy %b lg %b exp 0 0 1", resp0_valid, busy,
                         last_grant); end
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rr_tie got %b%b exp 10", req0_ready, req1_ready); end
    clear_inputs();
  endtask

  // Scoreboard: phase counts cycles since acceptance (0 none, 1 executing, 2 responding).
  task automatic test_random;
    logic        v0, v1, keep0, keep1, e0, e1, own, lg;
    logic [31:0] a0, b0, a1, b1, res;
    logic [3:0]  o0, o1, op;
    int          ph, ops;
    apply_reset();
    v0 = 0; v1 = 0; keep0 = 0; keep1 = 0; lg = 1; ph = 0; ops = 0;
    own = 0; res = 0; op = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; o0 = 0; o1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!keep0) begin
        v0 = ($urandom_range(0, 2) != 0); a0 = $urandom; b0 = $urandom;
        o0 = 4'($urandom_range(0, 15));
      end
      if (!keep1) begin
        v1 = ($urandom_range(0, 2) != 0); a1 = $urandom; b1 = $urandom;
        o1 = 4'($urandom_range(0, 15));
      end
      req0_valid = v0; req0_data1 = a0; req0_data2 = b0; req0_opcode = o0;
      req1_valid = v1; req1_data1 = a1; req1_data2 = b1; req1_opcode = o1;
      resp0_ready = 1'($urandom_range(0, 1));
      resp1_ready = 1'($urandom_range(0, 1));
      #1;
      e0 = (ph == 0) && v0 && (!v1 || lg);
      e1 = (ph == 0) && v1 && (!v0 || !lg);
      checks++; if (req0_ready !== e0 || req1_ready !== e1) begin
        errors++; $display("FAIL rnd_ready[%0d] got %b%b exp %b%b", c, req0_ready, req1_ready,
                           e0, e1); end
      checks++; if (busy !== (ph != 0) || last_grant !== lg) begin
        errors++; $display("FAIL rnd_state[%0d] got busy %b lg %b exp %b %b", c, busy,
                           last_grant, (ph != 0), lg); end
      checks++; if (alu_opcode !== ((ph == 1) ? op : 4'h0)) begin
        errors++; $display("FAIL rnd_aluop[%0d] got %h exp %h", c, alu_opcode,
                           (ph == 1) ? op : 4'h0); end
      checks++; if (resp0_valid !== (ph == 2 && !own) || resp1_valid !== (ph == 2 && own)) begin
        errors++; $display("FAIL rnd_valid[%0d] got %b%b exp phase %0d owner %b", c,
                           resp0_valid, resp1_valid, ph, own); end
      if (ph == 2) begin
        checks++; if ((own ? resp1_result : resp0_result) !== res) begin
          errors++; $display("FAIL rnd_result[%0d] got %h exp %h", c,
                             own ? resp1_result : resp0_result, res); end
      end
      keep0 = v0 && !e0;
      keep1 = v1 && !e1;
      if (e0 || e1) begin
        own = e1;
        op  = e1 ? o1 : o0;
        res = e1 ? alu_f(o1, a1, b1) : alu_f(o0, a0, b0);
        lg  = e1;
        ph  = 1;
      end else if (ph == 1) begin
        ph = 2;
      end else if (ph == 2 && (own ? resp1_ready : resp0_ready)) begin
        ph = 0;
        ops++;
      end
      tick();
    end
    checks++; if (ops < 20) begin
      errors++; $display("FAIL rnd_progress got %0d ops exp at least 20", ops); end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_add();
    test_tie_rr();
    test_back_pressure();
    test_fairness();
    test_invalid_opcode();
    test_reset_in_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
